// File: rtl/demux_2_to_1_sched_pkg.sv
// Shared types for the 2-output demux scheduler.
package demux_sched_pkg;

    typedef enum logic [1:0] {
        MODE_SEL   = 2'b00,
        MODE_ALT   = 2'b01,
        MODE_BURST = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Alternate and burst policies take their destination from the pointer;
    // the external-select and reserved encodings take it from S.
    function automatic logic uses_ptr(input mode_t m);
        return (m == MODE_ALT) || (m == MODE_BURST);
    endfunction

endpackage

// File: rtl/demux_2_to_1_sched_if.sv
// Producer and two-consumer valid/ready handshake bundle.
interface demux_sched_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             y0_valid;
    logic [WIDTH-1:0] y0_data;
    logic             y0_ready;
    logic             y1_valid;
    logic [WIDTH-1:0] y1_data;
    logic             y1_ready;

    // Environment side: produces words, consumes both channels.
    modport master (
        output in_valid, in_data, y0_ready, y1_ready,
        input  in_ready, y0_valid, y0_data, y1_valid, y1_data
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data, y0_ready, y1_ready,
        output in_ready, y0_valid, y0_data, y1_valid, y1_data
    );
endinterface

// File: rtl/demux_2_to_1_sched_dest_sel.sv
// Destination selector: alternation pointer, burst counter, mode-change detect.
module demux_dest_sel
    import demux_sched_pkg::*;
#(
    parameter int unsigned BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] MODE,
    input  logic       S,
    input  logic       accept,
    output logic       next_dest
);
    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] BCNT_LAST = CW'(BURST - 1);

    mode_t          mode;
    mode_t          mode_prev;
    logic           mode_chg;
    logic           ptr;
    logic           ptr_eff;
    logic [CW-1:0]  bcnt;
    logic [CW-1:0]  bcnt_eff;

    assign mode = mode_t'(MODE);

    // A mode change restarts ptr/bcnt in the same cycle, so an accept
    // coinciding with the change already sees the cleared values.
    always_comb begin
        mode_chg  = (mode != mode_prev);
        ptr_eff   = mode_chg ? 1'b0 : ptr;
        bcnt_eff  = mode_chg ? '0 : bcnt;
        next_dest = uses_ptr(mode) ? ptr_eff : S;
    end

    // Pointer / burst counter advance on each accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 1'b0;
            bcnt      <= '0;
            mode_prev <= MODE_SEL;
        end else begin
            mode_prev <= mode;
            ptr       <= ptr_eff;
            bcnt      <= bcnt_eff;
            if (accept) begin
                case (mode)
                    MODE_ALT: ptr <= ~ptr_eff;
                    MODE_BURST: begin
                        if (bcnt_eff == BCNT_LAST) begin
                            bcnt <= '0;
                            ptr  <= ~ptr_eff;
                        end else begin
                            bcnt <= bcnt_eff + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/demux_2_to_1_sched.sv
// Single-entry scheduling front end sharing one word stream between Y0 and Y1.
module demux_2_to_1_sched
    import demux_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    MODE,
    input  logic          S,
    demux_sched_if.slave  bus,
    output logic          dest,
    output logic          busy
);
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic             dest_q;
    logic             sel_dest;
    logic             drain;
    logic             accept;
    logic             in_ready;
    logic             full;

    demux_dest_sel #(
        .BURST (BURST)
    ) u_dest_sel (
        .clk       (clk),
        .rst       (rst),
        .MODE      (MODE),
        .S         (S),
        .accept    (accept),
        .next_dest (sel_dest)
    );

    // Handshake and next-state: a full register may accept while it drains.
    always_comb begin
        state_d  = state_q;
        drain    = (state_q == FULL) && (dest_q ? bus.y1_ready : bus.y0_ready);
        in_ready = !rst && ((state_q == EMPTY) || drain);
        accept   = bus.in_valid && in_ready;
        if (accept) begin
            state_d = FULL;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    // Holding register: loads on accept, clears when emptied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= bus.in_data;
                dest_q <= sel_dest;
            end else if (drain) begin
                data_q <= '0;
                dest_q <= 1'b0;
            end
        end
    end

    // Output gating: only the held word's channel sees valid/data.
    always_comb begin
        full         = (state_q == FULL);
        bus.in_ready = in_ready;
        bus.y0_valid = full && !dest_q;
        bus.y1_valid = full && dest_q;
        bus.y0_data  = (full && !dest_q) ? data_q : '0;
        bus.y1_data  = (full && dest_q) ? data_q : '0;
        dest         = full && dest_q;
        busy         = full;
    end

endmodule

// File: tb/tb_demux_2_to_1_sched.sv
// Self-checking bench for demux_2_to_1_sched: directed plan plus random traffic.
module tb_demux_2_to_1_sched;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned BURST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] MODE = 2'b00;
    logic       S = 1'b0;
    logic       dest;
    logic       busy;

    demux_sched_if #(.WIDTH(WIDTH)) bus ();

    demux_2_to_1_sched #(
        .WIDTH (WIDTH),
        .BURST (BURST)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .MODE (MODE),
        .S    (S),
        .bus  (bus),
        .dest (dest),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference: one-slot holding model; destination from accept count k
    // since the last mode change (alternate: k mod 2, burst: (k/BURST) mod 2).
    logic        m_full = 1'b0;
    logic [7:0]  m_data = '0;
    logic        m_dest = 1'b0;
    int unsigned m_k = 0;
    logic [1:0]  m_prev_mode = 2'b00;

    logic [7:0] got0[$];
    logic [7:0] got1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic [7:0] q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = (v << 8) | 64'(q[i]);
        return v;
    endfunction

    task automatic check_and_advance();
        logic e_ready, drn, acc, d;
        drn     = m_full && (m_dest ? bus.y1_ready : bus.y0_ready);
        e_ready = !rst && (!m_full || drn);
        chk("in_ready", bus.in_ready, e_ready);
        chk("y0_valid", bus.y0_valid, m_full && !m_dest);
        chk("y1_valid", bus.y1_valid, m_full && m_dest);
        chk("y0_data",  bus.y0_data, (m_full && !m_dest) ? m_data : 8'h00);
        chk("y1_data",  bus.y1_data, (m_full && m_dest) ? m_data : 8'h00);
        chk("dest",     dest, m_full && m_dest);
        chk("busy",     busy, m_full);
        if (bus.y0_valid && bus.y0_ready) got0.push_back(bus.y0_data);
        if (bus.y1_valid && bus.y1_ready) got1.push_back(bus.y1_data);
        if (rst) begin
            m_full = 1'b0; m_data = '0; m_dest = 1'b0; m_k = 0; m_prev_mode = 2'b00;
        end else begin
            if (MODE != m_prev_mode) m_k = 0;
            acc = bus.in_valid && e_ready;
            if (acc) begin
                case (MODE)
                    2'b01:   d = m_k[0];
                    2'b10:   d = ((m_k / BURST) % 2) != 0;
                    default: d = S;
                endcase
                m_full = 1'b1; m_data = bus.in_data; m_dest = d;
                if (MODE == 2'b01 || MODE == 2'b10) m_k++;
            end else if (drn) begin
                m_full = 1'b0; m_data = '0; m_dest = 1'b0;
            end
            m_prev_mode = MODE;
        end
    endtask

    task automatic step(input logic r, input logic [1:0] m, input logic s,
                        input logic iv, input logic [7:0] d,
                        input logic r0, input logic r1);
        rst = r; MODE = m; S = s;
        bus.in_valid = iv; bus.in_data = d;
        bus.y0_ready = r0; bus.y1_ready = r1;
        #1;
        check_and_advance();
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus.y0_ready = 1'b0; bus.y1_ready = 1'b0;
        @(negedge clk);

        // Reset, then one word to Y1 via external select.
        step(1, 2'b00, 0, 0, 8'h00, 0, 0);
        step(1, 2'b00, 0, 0, 8'h00, 0, 0);
        got0.delete(); got1.delete();
        step(0, 2'b00, 1, 1, 8'hA5, 0, 1);
        step(0, 2'b00, 1, 0, 8'h00, 0, 1);
        step(0, 2'b00, 1, 0, 8'h00, 0, 1);
        chk("t1_y1_count", 64'(got1.size()), 64'd1);
        chk("t1_y1_words", pack(got1), 64'hA5);
        chk("t1_y0_count", 64'(got0.size()), 64'd0);

        // Alternation, back-to-back.
        got0.delete(); got1.delete();
        for (int i = 1; i <= 6; i++) step(0, 2'b01, 0, 1, 8'(i), 1, 1);
        step(0, 2'b01, 0, 0, 8'h00, 1, 1);
        chk("t2_y0_words", pack(got0), 64'h010305);
        chk("t2_y1_words", pack(got1), 64'h020406);

        // Bursts of four.
        got0.delete(); got1.delete();
        for (int i = 1; i <= 10; i++) step(0, 2'b10, 0, 1, 8'(i), 1, 1);
        step(0, 2'b10, 0, 0, 8'h00, 1, 1);
        chk("t3_y0_words", pack(got0), 64'h01020304090A);
        chk("t3_y1_words", pack(got1), 64'h05060708);

        // Stalled Y0 blocks all input; drain and accept together on release.
        got0.delete(); got1.delete();
        step(0, 2'b00, 0, 1, 8'h11, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 1, 8'h22, 0, 1);
        step(0, 2'b00, 0, 1, 8'h22, 1, 1);
        step(0, 2'b00, 0, 0, 8'h00, 1, 1);
        chk("t4_y0_words", pack(got0), 64'h1122);
        chk("t4_y1_count", 64'(got1.size()), 64'd0);

        // Alternate for three words, then switch to burst.
        got0.delete(); got1.delete();
        step(0, 2'b01, 0, 1, 8'h31, 1, 1);
        step(0, 2'b01, 0, 1, 8'h32, 1, 1);
        step(0, 2'b01, 0, 1, 8'h33, 1, 1);
        for (int i = 1; i <= 5; i++) step(0, 2'b10, 0, 1, 8'(8'h40 + i), 1, 1);
        step(0, 2'b10, 0, 0, 8'h00, 1, 1);
        chk("t5_y0_words", pack(got0), 64'h313341424344);
        chk("t5_y1_words", pack(got1), 64'h3245);

        // Reset while holding a stalled Y1 word.
        got0.delete(); got1.delete();
        step(0, 2'b00, 1, 1, 8'h55, 1, 0);
        step(0, 2'b00, 1, 0, 8'h00, 1, 0);
        step(1, 2'b00, 1, 0, 8'h00, 0, 0);
        step(0, 2'b01, 0, 1, 8'h66, 1, 1);
        step(0, 2'b01, 0, 0, 8'h00, 1, 1);
        chk("t6_y0_words", pack(got0), 64'h66);
        chk("t6_y1_count", 64'(got1.size()), 64'd0);

        // Random traffic against the model.
        begin
            logic [1:0] m = 2'b00;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(15) == 0) m = 2'($urandom_range(3));
                step(($urandom_range(99) == 0), m, 1'($urandom()),
                     ($urandom_range(3) != 0), 8'($urandom()),
                     ($urandom_range(3) != 0), ($urandom_range(3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
